// File: rtl/lcd_ctrl_pkg.sv
// rtl/lcd_ctrl_pkg.sv - shared state encodings, init command table and long-delay command codes
package lcd_ctrl_pkg;

    typedef enum logic [2:0] {
        PWR_WAIT,
        INIT,
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        DELAY
    } lcd_state_t;

    localparam logic [2:0] INIT_LEN     = 3'd4;

    localparam logic [7:0] CMD_FUNC_SET = 8'h38;
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_HOME     = 8'h02;
    localparam logic [7:0] CMD_HOME_ALT = 8'h03;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        logic [7:0] v;
        case (idx)
            2'd0:    v = CMD_FUNC_SET;
            2'd1:    v = CMD_DISP_ON;
            2'd2:    v = CMD_CLEAR;
            default: v = CMD_ENTRY;
        endcase
        return v;
    endfunction

    // Clear and home are the only instructions that need the long settle time
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] d);
        return !rs && ((d == CMD_CLEAR) || (d == CMD_HOME) || (d == CMD_HOME_ALT));
    endfunction

endpackage

// File: rtl/lcd_ctrl_if.sv
// rtl/lcd_ctrl_if.sv - CPU-side write bus of the LCD controller
interface lcd_ctrl_if;
    logic       wr;
    logic       cmd;
    logic [7:0] din;
    logic       full;
    logic       ready;

    modport master (output wr, output cmd, output din, input full, input ready);
    modport slave  (input wr, input cmd, input din, output full, output ready);
endinterface

// File: rtl/lcd_fifo.sv
// rtl/lcd_fifo.sv - 4x9 request FIFO holding {cmd, din}
module lcd_fifo (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_push,
    input  logic       i_pop,
    input  logic [8:0] i_wdata,
    output logic [8:0] o_rdata,
    output logic       o_full,
    output logic       o_empty,
    output logic [2:0] o_count
);
    logic [8:0] r_mem [4];
    logic [1:0] r_wptr;
    logic [1:0] r_rptr;
    logic [2:0] r_count;
    logic       w_push_ok;
    logic       w_pop_ok;

    assign o_full    = (r_count == 3'd4);
    assign o_empty   = (r_count == 3'd0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rptr];
    // A push while full is still taken when the head leaves in the same cycle
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);

    always_ff @(posedge i_clk) begin
        if (w_push_ok)
            r_mem[r_wptr] <= i_wdata;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= 2'd0;
            r_rptr  <= 2'd0;
            r_count <= 3'd0;
        end else begin
            if (w_push_ok)
                r_wptr <= r_wptr + 2'd1;
            if (w_pop_ok)
                r_rptr <= r_rptr + 2'd1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/lcd_ctrl.sv
// rtl/lcd_ctrl.sv - HD44780-style LCD write controller with power-up init and queued CPU writes
module lcd_ctrl
    import lcd_ctrl_pkg::*;
#(
    parameter int SETUP_CYC   = 1,
    parameter int PULSE_CYC   = 4,
    parameter int SHORT_CYC   = 40,
    parameter int LONG_CYC    = 1600,
    parameter int POWERUP_CYC = 15000
) (
    input  logic        clk,
    input  logic        rst,
    lcd_ctrl_if.slave   bus,
    output logic        lcd_e,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic [7:0]  lcd_d
);
    localparam logic [15:0] L_PWR   = 16'(POWERUP_CYC - 1);
    localparam logic [15:0] L_SETUP = 16'(SETUP_CYC - 1);
    localparam logic [15:0] L_PULSE = 16'(PULSE_CYC - 1);
    localparam logic [15:0] L_SHORT = 16'(SHORT_CYC - 1);
    localparam logic [15:0] L_LONG  = 16'(LONG_CYC - 1);

    lcd_state_t  r_state;
    logic [15:0] r_cnt;
    logic [2:0]  r_init_idx;
    logic        r_e;
    logic        r_rs;
    logic [7:0]  r_d;

    logic        w_pop;
    logic        w_full;
    logic        w_empty;
    logic [2:0]  w_count;
    logic [8:0]  w_head;

    assign w_pop = (r_state == IDLE) && !w_empty;

    lcd_fifo u_fifo (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_push  (bus.wr),
        .i_pop   (w_pop),
        .i_wdata ({bus.cmd, bus.din}),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign bus.full  = w_full;
    assign bus.ready = (r_state == IDLE) && (w_count == 3'd0);
    assign lcd_e     = r_e;
    assign lcd_rs    = r_rs;
    assign lcd_d     = r_d;
    assign lcd_rw    = 1'b0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= PWR_WAIT;
            r_cnt      <= L_PWR;
            r_init_idx <= 3'd0;
            r_e        <= 1'b0;
            r_rs       <= 1'b0;
            r_d        <= 8'h00;
        end else begin
            case (r_state)
                PWR_WAIT: begin
                    if (r_cnt == 16'd0)
                        r_state <= INIT;
                    else
                        r_cnt <= r_cnt - 16'd1;
                end
                INIT: begin
                    r_rs       <= 1'b0;
                    r_d        <= init_cmd(r_init_idx[1:0]);
                    r_init_idx <= r_init_idx + 3'd1;
                    r_cnt      <= L_SETUP;
                    r_state    <= SETUP;
                end
                IDLE: begin
                    if (w_pop) begin
                        r_rs    <= ~w_head[8];
                        r_d     <= w_head[7:0];
                        r_cnt   <= L_SETUP;
                        r_state <= SETUP;
                    end
                end
                SETUP: begin
                    if (r_cnt == 16'd0) begin
                        r_e     <= 1'b1;
                        r_cnt   <= L_PULSE;
                        r_state <= PULSE;
                    end else
                        r_cnt <= r_cnt - 16'd1;
                end
                PULSE: begin
                    if (r_cnt == 16'd0) begin
                        r_e     <= 1'b0;
                        r_cnt   <= 16'd0;
                        r_state <= HOLD;
                    end else
                        r_cnt <= r_cnt - 16'd1;
                end
                HOLD: begin
                    r_cnt   <= is_long_cmd(r_rs, r_d) ? L_LONG : L_SHORT;
                    r_state <= DELAY;
                end
                DELAY: begin
                    if (r_cnt == 16'd0)
                        r_state <= (r_init_idx == INIT_LEN) ? IDLE : INIT;
                    else
                        r_cnt <= r_cnt - 16'd1;
                end
                default: r_state <= PWR_WAIT;
            endcase
        end
    end
endmodule
